blake2_msg_sched: RTL and testbench
===================================

BLAKE2_MSG_SCHED -- requirements
Module: blake2_msg_sched

Interface
REQ-001 SHALL have parameter BB, default 128, meaning block size in bytes (128 for BLAKE2b, 64 for BLAKE2s); power of two.
REQ-002 SHALL have parameter BB_clog2, default $clog2(BB), meaning the width of the in-block byte counter.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all logic on the rising edge.
REQ-004 SHALL have port reset  input  1  meaning synchronous, active-high reset.
REQ-005 SHALL have port start_i  input  1  meaning a one-cycle pulse that launches a hash job.
REQ-006 SHALL have port kk_i  input  8  meaning key length in bytes (0..64); sampled on the accepted start.
REQ-007 SHALL have port nn_i  input  8  meaning hash length in bytes; sampled on the accepted start.
REQ-008 SHALL have port ll_i  input  64  meaning message length in bytes, excluding the key; sampled on the accepted start.
REQ-009 SHALL have port src_valid_i, src_data_i, src_ready_o  in/in/out  1/8/1  meaning the source byte stream: key bytes first, then message bytes.
REQ-010 SHALL have port core_data_v_o, core_data_o  out/out  1/8  meaning bytes presented to the hash core.
REQ-011 SHALL have port core_ready_i  input  1  meaning the core accepts a byte this cycle.
REQ-012 SHALL have port core_block_first_o, core_block_last_o  out/out  1/1  meaning flags on every byte of the first and final block.
REQ-013 SHALL have port core_kk_o, core_nn_o, core_ll_o  out/out/out  8/8/64  meaning registered job parameters for the core.
REQ-014 SHALL have port core_valid_i  input  1  meaning the core has finished and its hash is valid.
REQ-015 SHALL have port busy_o, done_o  out/out  1/1  meaning a job is in progress, and a one-cycle completion pulse.

Function
REQ-016 SHALL implement states IDLE, KEY, MSG, PAD, WAIT_RES.
REQ-017 IDLE SHALL act on start_i only; it SHALL then latch kk/nn/ll and go to KEY if kk>0, MSG if ll>0, else PAD. start_i SHALL be ignored outside IDLE.
REQ-018 core_ll_o SHALL equal ll + (kk>0 ? BB : 0), modulo 2^64.
REQ-019 A byte transfer SHALL occur when core_data_v_o & core_ready_i; a source transfer when src_valid_i & src_ready_o.
REQ-020 In KEY/MSG: src_ready_o = core_ready_i, core_data_v_o = src_valid_i, core_data_o = src_data_i, combinationally, with zero latency.
REQ-021 In PAD: core_data_v_o=1, core_data_o=0x00, src_ready_o=0. In IDLE/WAIT_RES: core_data_v_o=0, src_ready_o=0.
REQ-022 The byte counter SHALL increment on each core transfer and wrap from BB-1 to 0, marking a block boundary.
REQ-023 KEY SHALL pass kk bytes, then PAD the block to BB bytes. After the boundary: MSG if ll>0, else WAIT_RES.
REQ-024 MSG SHALL decrement a 64-bit remaining count per transfer. At 0: PAD if the counter is nonzero, else WAIT_RES.
REQ-025 PAD SHALL go to WAIT_RES when the counter wraps. For ll=0 and kk=0, PAD SHALL emit exactly one all-zero block.
REQ-026 core_block_first_o SHALL be high on all bytes of block 0 only.
REQ-027 core_block_last_o SHALL be high on all bytes of block N-1, where N = ceil(ll/BB) + (kk>0), minimum 1. When N=1, both flags SHALL be high.
REQ-028 WAIT_RES SHALL go to IDLE on core_valid_i, asserting done_o in that same cycle. core_valid_i SHALL be ignored in other states.
REQ-029 busy_o SHALL be high in every state except IDLE.
REQ-030 Source stall (src_valid_i=0) or core stall (core_ready_i=0) SHALL freeze all counters and state; no byte lost or duplicated.

Reset
REQ-031 reset SHALL take priority over every other input, including mid-job.
REQ-032 After reset: state IDLE, counters 0, and every output 0, including core_kk_o/core_nn_o/core_ll_o.
REQ-033 After reset, the next job SHALL start with block_first semantics.

Verification
REQ-034 BB=128, kk=0, ll=3, src 61 62 63, core_ready_i=1 -> 3 data bytes then 125 x 00; first=last=1 on all 128 bytes; core_ll_o=3.
REQ-035 kk=0, ll=0 -> 128 x 00, first=last=1; core_ll_o=0; on core_valid_i, done_o pulses once and the state returns to IDLE.
REQ-036 kk=0, ll=200 -> block 0 is 128 src bytes with first=1, last=0; block 1 is 72 src bytes + 56 x 00 with first=0, last=1.
REQ-037 kk=32, ll=0 -> 32 key bytes + 96 x 00, first=last=1; core_ll_o=128. With kk=32, ll=1 -> 2 blocks; core_ll_o=129.
REQ-038 ll=130 with core_ready_i low for 5 cycles at byte 64 and src_valid_i low for 3 cycles at byte 100 -> src_ready_o tracks core_ready_i; the output byte sequence is identical to the unstalled run.
REQ-039 reset pulsed at byte 50 of ll=200 -> next cycle IDLE, busy_o=0, all outputs 0; a new start (ll=3) behaves exactly as REQ-034.

Source files
------------

// File: rtl/blake2_msg_sched.sv
// blake2_msg_sched: feeds a BLAKE2 core with the zero-padded key block, then the message bytes,
// then zero padding up to the final block boundary, flagging the first and last blocks.
module blake2_msg_sched #(
   parameter int BB = 128,
   parameter int BB_clog2 = $clog2(BB)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start_i,
   input  logic [7:0]          kk_i,
   input  logic [7:0]          nn_i,
   input  logic [63:0]         ll_i,
   input  logic                src_valid_i,
   input  logic [7:0]          src_data_i,
   output logic                src_ready_o,
   output logic                core_data_v_o,
   output logic [7:0]          core_data_o,
   input  logic                core_ready_i,
   output logic                core_block_first_o,
   output logic                core_block_last_o,
   output logic [7:0]          core_kk_o,
   output logic [7:0]          core_nn_o,
   output logic [63:0]         core_ll_o,
   input  logic                core_valid_i,
   output logic                busy_o,
   output logic                done_o
);
   localparam logic [2:0] IDLE = 3'd0, KEY = 3'd1, MSG = 3'd2, PAD = 3'd3, WAIT_RES = 3'd4;
   logic [2:0] state;
   logic [BB_clog2-1:0] cnt;
   logic [63:0] rem;
   logic first, pass, emit, xfer, wrap, fits;
   assign pass = (state == KEY) || (state == MSG);
   assign emit = pass || (state == PAD);
   assign src_ready_o = pass & core_ready_i;
   assign core_data_v_o = pass ? src_valid_i : (state == PAD);
   assign core_data_o = pass ? src_data_i : 8'h00;
   assign xfer = core_data_v_o & core_ready_i;
   assign wrap = &cnt;
   // the current message block is the last one when the remaining bytes fit in what is left of it
   assign fits = ({1'b0, rem} + 65'(cnt)) <= 65'(BB);
   assign core_block_first_o = emit & first;
   assign core_block_last_o = emit & ((state == MSG) ? fits : (rem == 64'd0));
   assign busy_o = state != IDLE;
   assign done_o = (state == WAIT_RES) & core_valid_i;
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt <= '0;
         rem <= '0;
         first <= 1'b0;
         core_kk_o <= '0;
         core_nn_o <= '0;
         core_ll_o <= '0;
      end else begin
         if (xfer) cnt <= cnt + 1'b1;
         if (xfer && wrap) first <= 1'b0;
         if (state == MSG && xfer) rem <= rem - 64'd1;
         case (state)
            IDLE: if (start_i) begin
               core_kk_o <= kk_i;
               core_nn_o <= nn_i;
               core_ll_o <= ll_i + ((kk_i != 8'd0) ? 64'(BB) : 64'd0);
               rem <= ll_i;
               first <= 1'b1;
               cnt <= '0;
               state <= (kk_i != 8'd0) ? KEY : (ll_i != 64'd0) ? MSG : PAD;
            end
            KEY: if (xfer && 8'(cnt) == core_kk_o - 8'd1)
               state <= !wrap ? PAD : (rem != 64'd0) ? MSG : WAIT_RES;
            MSG: if (xfer && rem == 64'd1) state <= wrap ? WAIT_RES : PAD;
            // a pad that ends the key block still has message bytes pending
            PAD: if (xfer && wrap) state <= (rem != 64'd0) ? MSG : WAIT_RES;
            WAIT_RES: if (core_valid_i) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_blake2_msg_sched.sv
// tb_blake2_msg_sched: directed jobs checking byte stream, block flags, stalls, done and reset.
module tb_blake2_msg_sched;
   logic clk = 1'b0, reset = 1'b1, start_i = 1'b0, src_valid_i = 1'b0, core_ready_i = 1'b0, core_valid_i = 1'b0;
   logic [7:0] kk_i = '0, nn_i = '0, src_data_i = '0;
   logic [63:0] ll_i = '0;
   logic [7:0] core_data_o, core_kk_o, core_nn_o;
   logic [63:0] core_ll_o;
   logic src_ready_o, core_data_v_o, core_block_first_o, core_block_last_o, busy_o, done_o;
   int n_chk = 0, n_fail = 0;
   always #5 clk = ~clk;
   blake2_msg_sched dut (
      .clk(clk), .reset(reset), .start_i(start_i), .kk_i(kk_i), .nn_i(nn_i), .ll_i(ll_i),
      .src_valid_i(src_valid_i), .src_data_i(src_data_i), .src_ready_o(src_ready_o),
      .core_data_v_o(core_data_v_o), .core_data_o(core_data_o), .core_ready_i(core_ready_i),
      .core_block_first_o(core_block_first_o), .core_block_last_o(core_block_last_o),
      .core_kk_o(core_kk_o), .core_nn_o(core_nn_o), .core_ll_o(core_ll_o),
      .core_valid_i(core_valid_i), .busy_o(busy_o), .done_o(done_o)
   );
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   function automatic logic [7:0] pat(input int j);
      return 8'(j + 97);
   endfunction
   task automatic check_idle(input string tag);
      check({tag, ":busy"}, 64'(busy_o), 64'd0);
      check({tag, ":dv"}, 64'(core_data_v_o), 64'd0);
      check({tag, ":srdy"}, 64'(src_ready_o), 64'd0);
      check({tag, ":flags"}, 64'({core_block_first_o, core_block_last_o, done_o}), 64'd0);
      check({tag, ":ll"}, core_ll_o, 64'd0);
      check({tag, ":kknn"}, 64'({core_kk_o, core_nn_o}), 64'd0);
   endtask
   task automatic run_job(input string name, input int kk, input int ll, input int cs_at, input int ss_at, input int rst_at);
      int nblk, total, kbase, k, j, m, cs_rem, ss_rem, derr, ferr, lerr, rerr, dnerr, extra;
      bit cs_done, ss_done, insrc;
      logic [7:0] eb;
      nblk = (ll + 127) / 128 + ((kk > 0) ? 1 : 0);
      if (nblk == 0) nblk = 1;
      total = nblk * 128;
      kbase = (kk > 0) ? 128 : 0;
      k = 0; j = 0; cs_rem = 0; ss_rem = 0; derr = 0; ferr = 0; lerr = 0; rerr = 0; dnerr = 0; extra = 0;
      cs_done = 0; ss_done = 0;
      @(negedge clk);
      start_i = 1'b1; kk_i = 8'(kk); nn_i = 8'h40; ll_i = 64'(ll);
      @(negedge clk);
      start_i = 1'b0;
      check({name, ":core_ll"}, core_ll_o, 64'(ll + kbase));
      check({name, ":core_kk"}, 64'(core_kk_o), 64'(kk));
      check({name, ":core_nn"}, 64'(core_nn_o), 64'h40);
      check({name, ":busy"}, 64'(busy_o), 64'd1);
      for (int c = 0; c < 3000 && k < total; c++) begin
         if (rst_at >= 0 && k == rst_at) begin
            reset = 1'b1; src_valid_i = 1'b0; start_i = 1'b0; core_valid_i = 1'b0;
            @(negedge clk);
            reset = 1'b0;
            #1;
            check_idle({name, ":rst"});
            return;
         end
         if (k == cs_at && !cs_done) begin cs_done = 1; cs_rem = 5; end
         if (k == ss_at && !ss_done) begin ss_done = 1; ss_rem = 3; end
         core_ready_i = cs_rem == 0;
         src_valid_i = (j < kk + ll) && ss_rem == 0;
         src_data_i = pat(j);
         start_i = k == 20;
         kk_i = 8'h3f; ll_i = 64'd999;
         core_valid_i = k == 5;
         #1;
         insrc = k < kk || (k >= kbase && k < kbase + ll);
         if (src_ready_o !== (insrc ? core_ready_i : 1'b0)) rerr++;
         if (done_o) dnerr++;
         if (core_data_v_o && core_ready_i) begin
            m = k - kbase;
            eb = (k < kk) ? pat(k) : (k < kbase || m >= ll) ? 8'h00 : pat(kk + m);
            if (core_data_o !== eb) derr++;
            if (core_block_first_o !== (k / 128 == 0)) ferr++;
            if (core_block_last_o !== (k / 128 == nblk - 1)) lerr++;
            k++;
         end
         if (src_valid_i && src_ready_o) j++;
         if (cs_rem > 0) cs_rem--;
         if (ss_rem > 0) ss_rem--;
         @(negedge clk);
      end
      start_i = 1'b0; core_valid_i = 1'b0; src_valid_i = 1'b0; core_ready_i = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         if (core_data_v_o) extra++;
         if (done_o) dnerr++;
         @(negedge clk);
      end
      check({name, ":bytes"}, 64'(k), 64'(total));
      check({name, ":src_used"}, 64'(j), 64'(kk + ll));
      check({name, ":data_err"}, 64'(derr), 64'd0);
      check({name, ":first_err"}, 64'(ferr), 64'd0);
      check({name, ":last_err"}, 64'(lerr), 64'd0);
      check({name, ":ready_err"}, 64'(rerr), 64'd0);
      check({name, ":early_done"}, 64'(dnerr), 64'd0);
      check({name, ":extra"}, 64'(extra), 64'd0);
      check({name, ":ll_kept"}, core_ll_o, 64'(ll + kbase));
      check({name, ":wait_busy"}, 64'(busy_o), 64'd1);
      core_valid_i = 1'b1;
      #1;
      check({name, ":done"}, 64'(done_o), 64'd1);
      @(negedge clk);
      core_valid_i = 1'b0;
      #1;
      check({name, ":idle_busy"}, 64'(busy_o), 64'd0);
      check({name, ":done_once"}, 64'(done_o), 64'd0);
   endtask
   initial begin
      repeat (3) @(negedge clk);
      check_idle("reset");
      reset = 1'b0;
      @(negedge clk);
      check("post_reset_busy", 64'(busy_o), 64'd0);
      run_job("ll3", 0, 3, -1, -1, -1);
      run_job("ll0", 0, 0, -1, -1, -1);
      run_job("ll200", 0, 200, -1, -1, -1);
      run_job("ll128", 0, 128, -1, -1, -1);
      run_job("kk32_ll0", 32, 0, -1, -1, -1);
      run_job("kk32_ll1", 32, 1, -1, -1, -1);
      run_job("stall130", 0, 130, 64, 100, -1);
      run_job("rst200", 0, 200, -1, -1, 50);
      run_job("ll3_again", 0, 3, -1, -1, -1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
